ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_clk_filter.sv | 56 +++++
 rtl/ps2_host_tx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: host-transmit FSM states, command bytes,
// the latched frame bundle and an odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } tx_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  typedef struct packed {
    logic [7:0] data;
    logic       parity;
  } tx_frame_t;

  function automatic logic odd_parity(
    input logic [7:0] b
  );
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioner: 2-flop synchronizers on clock and data,
// glitch filter on the clock and a one-cycle falling-edge tick.
//   clk, reset : system clock, synchronous active-high reset
//   ps2c_in    : raw PS/2 clock line (asynchronous)
//   ps2d_in    : raw PS/2 data line (asynchronous)
//   ps2c_filt  : filtered clock level (1 after reset)
//   ps2d_sync  : synchronized data level
//   fall_tick  : one-cycle pulse on a filtered 1->0 clock transition
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic ps2c_filt,
  output logic ps2d_sync,
  output logic fall_tick
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    c_sync;
  logic [1:0]    d_sync;
  logic [CW-1:0] cnt;
  logic          c_s;

  assign c_s       = c_sync[1];
  assign ps2d_sync = d_sync[1];

  // A new level is accepted only after FILTER_LEN consecutive
  // samples disagree with the current filtered level.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync    <= 2'b11;
      d_sync    <= 2'b11;
      cnt       <= '0;
      ps2c_filt <= 1'b1;
      fall_tick <= 1'b0;
    end else begin
      c_sync    <= {c_sync[0], ps2c_in};
      d_sync    <= {d_sync[0], ps2d_in};
      fall_tick <= 1'b0;
      if (c_s == ps2c_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt       <= '0;
        ps2c_filt <= c_s;
        fall_tick <= ~c_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (open-drain line control).
//   clk, reset : system clock, synchronous active-high reset
//   tx_start   : one-cycle request to send tx_data
//   tx_data    : command byte
//   ps2c_in    : raw PS/2 clock line level
//   ps2d_in    : raw PS/2 data line level
//   ps2c_oe    : 1 = pull clock low, 0 = release
//   ps2d_oe    : 1 = pull data low, 0 = release
//   tx_busy    : transfer in progress
//   tx_done    : one-cycle pulse, byte sent and ACK seen
//   tx_err     : one-cycle pulse, timeout or missing ACK
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6500,
  parameter int TIMEOUT_CYCLES = 1300000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int MAXC =
    (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  logic          ps2c_filt;
  logic          ps2d_sync;
  logic          fall_tick;

  tx_state_e     state_q, state_d;
  tx_frame_t     frame_q, frame_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic          c_oe_q, c_oe_d;
  logic          d_oe_q, d_oe_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          tmo_state;
  logic          timeout;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filt (
    .clk       (clk),
    .reset     (reset),
    .ps2c_in   (ps2c_in),
    .ps2d_in   (ps2d_in),
    .ps2c_filt (ps2c_filt),
    .ps2d_sync (ps2d_sync),
    .fall_tick (fall_tick)
  );

  assign tmo_state =
    (state_q == START) || (state_q == SHIFT) ||
    (state_q == ACK)   || (state_q == WAIT_IDLE);

  // A device edge arriving in the same cycle restarts the window.
  assign timeout = tmo_state && !fall_tick &&
    (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q + 1'b1;
    c_oe_d  = 1'b0;
    d_oe_d  = d_oe_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (fall_tick && tmo_state) begin
      cnt_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        d_oe_d = 1'b0;
        if (tx_start) begin
          frame_d.data   = tx_data;
          frame_d.parity = odd_parity(tx_data);
          state_d        = INHIBIT;
          c_oe_d         = 1'b1;
        end
      end
      INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          state_d = START;
          d_oe_d  = 1'b1;
        end else begin
          c_oe_d = 1'b1;
        end
      end
      START: begin
        state_d = SHIFT;
        bit_d   = '0;
      end
      SHIFT: begin
        if (fall_tick) begin
          bit_d = bit_q + 4'd1;
          unique case (1'b1)
            (bit_q < 4'd8):
              d_oe_d = ~frame_q.data[bit_q[2:0]];
            (bit_q == 4'd8):
              d_oe_d = ~frame_q.parity;
            default: begin
              d_oe_d  = 1'b0;
              state_d = ACK;
            end
          endcase
        end
      end
      ACK: begin
        if (fall_tick) begin
          if (ps2d_sync) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (ps2c_filt && ps2d_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A finished handshake wins over a timeout in the same cycle.
    if (timeout && !done_d) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    if (state_d == IDLE) begin
      c_oe_d = 1'b0;
      d_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      c_oe_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      c_oe_q  <= c_oe_d;
      d_oe_q  <= d_oe_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ps2c_oe = c_oe_q;
  assign ps2d_oe = d_oe_q;
  assign tx_done = done_q;
  assign tx_err  = err_q;
  assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a PS/2 device
// model that clocks frames, samples bits and drives the ACK.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 6500;
  localparam int TMO  = 3000;
  localparam int FLT  = 8;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic       dev_c_low;
  logic       dev_d_low;

  logic [10:0] line_bits;
  int checks = 0;
  int fails  = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_both = 0;
  int n_bad_rel  = 0;
  int n_bad_busy = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FLT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_err   (tx_err)
  );

  // wired-AND open-drain lines with pull-ups
  assign ps2c_in = ~(ps2c_oe | dev_c_low);
  assign ps2d_in = ~(ps2d_oe | dev_d_low);

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done) n_done++;
    if (tx_err) n_err++;
    if (tx_done && tx_err) n_both++;
    if ((tx_done || tx_err) && (ps2c_oe || ps2d_oe))
      n_bad_rel++;
    if ((tx_done || tx_err) && tx_busy)
      n_bad_busy++;
  end

  // expected 11 line bits: start, data LSB first, odd parity, stop
  function automatic logic [10:0] model_bits(
    input logic [7:0] b
  );
    logic [10:0] m;
    m[0] = 1'b0;
    for (int i = 0; i < 8; i++) m[i+1] = b[i];
    m[9]  = (($countones(b) % 2) == 0);
    m[10] = 1'b1;
    return m;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // waits out the inhibit, counts its length, samples the start bit
  task automatic dev_wait_rts(output int inh,
                              output logic start_ok);
    int t;
    t   = 0;
    inh = 0;
    while (!ps2c_oe && t < 100) begin
      @(negedge clk);
      t++;
    end
    while (ps2c_oe && inh < 2 * INH) begin
      @(negedge clk);
      inh++;
    end
    start_ok = ps2d_oe && !ps2c_oe;
  endtask

  task automatic dev_start_bit();
    repeat (HALF) @(negedge clk);
    line_bits[0] = ps2d_in;
  endtask

  // device clock cycle k: fall, hold low, rise and sample data
  task automatic dev_edge(input int k);
    dev_c_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_c_low = 1'b0;
    line_bits[k] = ps2d_in;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic dev_ack(input logic ack);
    repeat (HALF / 2) @(negedge clk);
    dev_d_low = ack;
    repeat (HALF / 2) @(negedge clk);
    dev_c_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_c_low = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    dev_d_low = 1'b0;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic wait_pulse(input int d0, input int e0);
    int t;
    t = 0;
    while (n_done == d0 && n_err == e0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ps2c_oe !== 1'b0) begin
      fails++;
      $display("FAIL reset_c_oe: got %b want 0", ps2c_oe);
    end
    checks++;
    if (ps2d_oe !== 1'b0) begin
      fails++;
      $display("FAIL reset_d_oe: got %b want 0", ps2d_oe);
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: got %b want 0", tx_busy);
    end
    checks++;
    if ({tx_done, tx_err} !== 2'b00) begin
      fails++;
      $display("FAIL reset_pulses: got %b want 00",
               {tx_done, tx_err});
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_frame(input logic [7:0] b,
                            input string name);
    int inh, d0, e0;
    logic sok;
    logic [10:0] exp;
    exp = model_bits(b);
    d0  = n_done;
    e0  = n_err;
    send(b);
    dev_wait_rts(inh, sok);
    checks++;
    if (inh != INH) begin
      fails++;
      $display("FAIL %s_inhibit: got %0d want %0d",
               name, inh, INH);
    end
    checks++;
    if (sok !== 1'b1) begin
      fails++;
      $display("FAIL %s_start_edge: got %b want 1", name, sok);
    end
    checks++;
    if (tx_busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy_mid: got %b want 1", name, tx_busy);
    end
    dev_start_bit();
    for (int k = 1; k <= 10; k++) dev_edge(k);
    dev_ack(1'b1);
    wait_pulse(d0, e0);
    checks++;
    if (line_bits !== exp) begin
      fails++;
      $display("FAIL %s_bits: got %b want %b",
               name, line_bits, exp);
    end
    checks++;
    if (n_done - d0 != 1) begin
      fails++;
      $display("FAIL %s_done: got %0d pulses want 1",
               name, n_done - d0);
    end
    checks++;
    if (n_err - e0 != 0) begin
      fails++;
      $display("FAIL %s_err: got %0d pulses want 0",
               name, n_err - e0);
    end
    checks++;
    if ({tx_busy, ps2c_oe, ps2d_oe} !== 3'b000) begin
      fails++;
      $display("FAIL %s_idle: got %b want 000", name,
               {tx_busy, ps2c_oe, ps2d_oe});
    end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_commands();
    test_frame(CMD_ENABLE, "F4");
    test_frame(CMD_SET_LEDS, "ED");
    test_frame(CMD_RESET, "FF");
    test_frame(8'h00, "00");
    test_frame(8'($urandom), "rand");
  endtask

  task automatic test_timeout();
    int inh, d0, e0, lat;
    logic sok;
    d0 = n_done;
    e0 = n_err;
    send(8'($urandom));
    dev_wait_rts(inh, sok);
    lat = 0;
    while (!tx_err && !tx_done && lat < TMO + 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat < TMO || lat > TMO + 2) begin
      fails++;
      $display("FAIL tmo_latency: got %0d want %0d..%0d",
               lat, TMO, TMO + 2);
    end
    checks++;
    if ({ps2c_oe, ps2d_oe} !== 2'b00) begin
      fails++;
      $display("FAIL tmo_release: got %b want 00",
               {ps2c_oe, ps2d_oe});
    end
    repeat (10) @(negedge clk);
    checks++;
    if (n_err - e0 != 1) begin
      fails++;
      $display("FAIL tmo_err: got %0d pulses want 1",
               n_err - e0);
    end
    checks++;
    if (n_done - d0 != 0) begin
      fails++;
      $display("FAIL tmo_done: got %0d pulses want 0",
               n_done - d0);
    end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_no_ack_and_restart();
    int inh, d0, e0;
    logic sok;
    logic [7:0] b;
    b  = 8'($urandom);
    d0 = n_done;
    e0 = n_err;
    send(b);
    dev_wait_rts(inh, sok);
    dev_start_bit();
    for (int k = 1; k <= 3; k++) dev_edge(k);
    @(negedge clk);
    tx_data  = ~b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int k = 4; k <= 10; k++) dev_edge(k);
    dev_ack(1'b0);
    wait_pulse(d0, e0);
    checks++;
    if (line_bits !== model_bits(b)) begin
      fails++;
      $display("FAIL noack_bits: got %b want %b",
               line_bits, model_bits(b));
    end
    checks++;
    if (n_err - e0 != 1) begin
      fails++;
      $display("FAIL noack_err: got %0d pulses want 1",
               n_err - e0);
    end
    checks++;
    if (n_done - d0 != 0) begin
      fails++;
      $display("FAIL noack_done: got %0d pulses want 0",
               n_done - d0);
    end
    repeat (100) @(negedge clk);
    checks++;
    if ({tx_busy, ps2c_oe, ps2d_oe} !== 3'b000) begin
      fails++;
      $display("FAIL noack_idle: got %b want 000",
               {tx_busy, ps2c_oe, ps2d_oe});
    end
  endtask

  task automatic test_reset_mid();
    int inh, d0, e0;
    logic sok;
    d0 = n_done;
    e0 = n_err;
    send(CMD_SET_LEDS);
    dev_wait_rts(inh, sok);
    dev_start_bit();
    for (int k = 1; k <= 4; k++) dev_edge(k);
    dev_c_low = 1'b1;
    repeat (HALF) @(negedge clk);
    checks++;
    if (ps2d_oe !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_bit4: got %b want 1", ps2d_oe);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ps2c_oe, ps2d_oe, tx_busy} !== 3'b000) begin
      fails++;
      $display("FAIL rstmid_release: got %b want 000",
               {ps2c_oe, ps2d_oe, tx_busy});
    end
    reset     = 1'b0;
    dev_c_low = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if ((n_done != d0) || (n_err != e0)) begin
      fails++;
      $display("FAIL rstmid_pulses: got done %0d err %0d want 0 0",
               n_done - d0, n_err - e0);
    end
    test_frame(CMD_ENABLE, "F4_after_reset");
  endtask

  task automatic test_invariants();
    checks++;
    if (n_both != 0) begin
      fails++;
      $display("FAIL inv_both: got %0d want 0", n_both);
    end
    checks++;
    if (n_bad_rel != 0) begin
      fails++;
      $display("FAIL inv_release: got %0d want 0", n_bad_rel);
    end
    checks++;
    if (n_bad_busy != 0) begin
      fails++;
      $display("FAIL inv_busy: got %0d want 0", n_bad_busy);
    end
  endtask

  initial begin
    test_reset();
    test_commands();
    test_timeout();
    test_no_ack_and_restart();
    test_reset_mid();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
